// File: rtl/neuromorphic_x1_ctrl.sv
// Wishbone classic slave that drives the 32x32 ReRAM macro: shapes write pulses,
// holds read requests, waits on func_ack with a timeout and tracks macro queue depth.
module neuromorphic_x1_ctrl #(
  parameter logic [15:0] TIMEOUT_RST = 16'd2047,
  parameter int          MAX_PEND    = 32,
  parameter int          ISSUE_GAP   = 2
) (
  input  logic        CLKin,
  input  logic        RSTin,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        EN,
  output logic        R_WB,
  output logic [31:0] DI,
  output logic [31:0] AD,
  output logic [3:0]  SEL,
  input  logic [31:0] DO,
  input  logic        func_ack
);

  typedef enum logic [2:0] {IDLE, GAP, WR_ISSUE, WR_WAIT, RD_WAIT, ACK} state_t;

  localparam logic [5:0] PEND_MAX = 6'(MAX_PEND);
  localparam logic [7:0] GAP_LOAD = 8'(ISSUE_GAP);

  state_t      state, state_d;
  logic [7:0]  gap_cnt, gap_d;
  logic [15:0] tmo_cnt, tmo_d;
  logic [15:0] timeout_reg, timeout_d;
  logic [5:0]  pend_cnt, pend_d;
  logic        flag_ovf, flag_unf, flag_tmo;
  logic        ovf_d, unf_d, tmo_flag_d;
  logic        ovf_set, unf_set, tmo_set;
  logic [2:0]  w1c;
  logic        macro_op, macro_op_d;
  logic        ack_d, en_d, rwb_d;
  logic [31:0] dat_d, di_d, ad_d;
  logic [3:0]  sel_d;

  logic        req;
  logic        busy;
  logic [15:0] eff_timeout;
  logic [31:0] status_word;

  assign req         = wbs_cyc_i & wbs_stb_i;
  assign busy        = (state != IDLE) || (gap_cnt != 8'd0);
  assign eff_timeout = (timeout_reg == 16'd0) ? 16'd1 : timeout_reg;
  assign status_word = {13'd0, flag_tmo, flag_unf, flag_ovf, 7'd0, busy, 2'd0, pend_cnt};

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    gap_d      = gap_cnt;
    tmo_d      = tmo_cnt;
    timeout_d  = timeout_reg;
    pend_d     = pend_cnt;
    macro_op_d = macro_op;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    tmo_set    = 1'b0;
    w1c        = 3'b000;
    ack_d      = 1'b0;
    dat_d      = wbs_dat_o;
    en_d       = EN;
    rwb_d      = R_WB;
    di_d       = DI;
    ad_d       = AD;
    sel_d      = SEL;

    case (state)
      IDLE: begin
        // A master samples ack on the edge after it rises, so the same strobe
        // must not be taken twice while ack is still showing.
        if (req && !wbs_ack_o && gap_cnt == 8'd0) begin
          macro_op_d = 1'b0;
          state_d    = ACK;
          case (wbs_adr_i[3:2])
            2'd0: begin
              if (wbs_we_i) begin
                if (pend_cnt >= PEND_MAX) begin
                  ovf_set = 1'b1;
                end else begin
                  di_d       = wbs_dat_i;
                  ad_d       = wbs_adr_i;
                  sel_d      = wbs_sel_i;
                  rwb_d      = 1'b0;
                  en_d       = 1'b1;
                  macro_op_d = 1'b1;
                  state_d    = WR_ISSUE;
                end
              end else if (pend_cnt == 6'd0) begin
                unf_set = 1'b1;
                dat_d   = 32'd0;
              end else begin
                ad_d       = wbs_adr_i;
                sel_d      = wbs_sel_i;
                rwb_d      = 1'b1;
                en_d       = 1'b1;
                tmo_d      = eff_timeout;
                macro_op_d = 1'b1;
                state_d    = RD_WAIT;
              end
            end
            2'd1: begin
              if (wbs_we_i) w1c   = wbs_dat_i[18:16];
              else          dat_d = status_word;
            end
            2'd2: begin
              if (wbs_we_i) timeout_d = wbs_dat_i[15:0];
              else          dat_d     = {16'd0, timeout_reg};
            end
            default: begin
              if (!wbs_we_i) dat_d = 32'd0;
            end
          endcase
        end
      end

      WR_ISSUE: begin
        en_d    = 1'b0;
        tmo_d   = eff_timeout;
        state_d = WR_WAIT;
      end

      WR_WAIT: begin
        if (func_ack) begin
          if (pend_cnt < PEND_MAX) pend_d = pend_cnt + 6'd1;
          state_d = ACK;
        end else if (tmo_cnt <= 16'd1) begin
          tmo_set = 1'b1;
          state_d = ACK;
        end else begin
          tmo_d = tmo_cnt - 16'd1;
        end
      end

      RD_WAIT: begin
        // EN stays high here: the macro abandons a read the moment EN drops.
        if (func_ack) begin
          dat_d = DO;
          if (pend_cnt != 6'd0) pend_d = pend_cnt - 6'd1;
          en_d    = 1'b0;
          state_d = ACK;
        end else if (tmo_cnt <= 16'd1) begin
          dat_d   = 32'hFFFF_FFFF;
          en_d    = 1'b0;
          tmo_set = 1'b1;
          state_d = ACK;
        end else begin
          tmo_d = tmo_cnt - 16'd1;
        end
      end

      ACK: begin
        ack_d = wbs_cyc_i;
        if (macro_op && GAP_LOAD != 8'd0) begin
          gap_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          gap_d   = 8'd0;
          state_d = IDLE;
        end
      end

      GAP: begin
        if (gap_cnt <= 8'd1) begin
          gap_d   = 8'd0;
          state_d = IDLE;
        end else begin
          gap_d = gap_cnt - 8'd1;
        end
      end

      default: state_d = IDLE;
    endcase

    ovf_d      = (flag_ovf & ~w1c[0]) | ovf_set;
    unf_d      = (flag_unf & ~w1c[1]) | unf_set;
    tmo_flag_d = (flag_tmo & ~w1c[2]) | tmo_set;
  end

  // NOTE: state elements use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLKin or negedge RSTin) begin
    if (!RSTin) begin
      state       <= IDLE;
      gap_cnt     <= 8'd0;
      tmo_cnt     <= 16'd0;
      timeout_reg <= TIMEOUT_RST;
      pend_cnt    <= 6'd0;
      flag_ovf    <= 1'b0;
      flag_unf    <= 1'b0;
      flag_tmo    <= 1'b0;
      macro_op    <= 1'b0;
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'd0;
      EN          <= 1'b0;
      R_WB        <= 1'b0;
      DI          <= 32'd0;
      AD          <= 32'd0;
      SEL         <= 4'd0;
    end else begin
      state       <= state_d;
      gap_cnt     <= gap_d;
      tmo_cnt     <= tmo_d;
      timeout_reg <= timeout_d;
      pend_cnt    <= pend_d;
      flag_ovf    <= ovf_d;
      flag_unf    <= unf_d;
      flag_tmo    <= tmo_flag_d;
      macro_op    <= macro_op_d;
      wbs_ack_o   <= ack_d;
      wbs_dat_o   <= dat_d;
      EN          <= en_d;
      R_WB        <= rwb_d;
      DI          <= di_d;
      AD          <= ad_d;
      SEL         <= sel_d;
    end
  end

endmodule

// File: tb/tb_neuromorphic_x1_ctrl.sv
// Bench for neuromorphic_x1_ctrl: behavioural macro, EN pulse monitor, vector table,
// corner-case sequences and a random run against a queue-based reference model.
module tb_neuromorphic_x1_ctrl;

  localparam int RD_DLY = 44;
  localparam int MAXW   = 3000;

  logic        CLKin = 1'b0;
  logic        RSTin = 1'b0;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0, wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        EN, R_WB;
  logic [31:0] DI, AD;
  logic [3:0]  SEL;
  logic [31:0] DO = 32'd0;
  logic        func_ack = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  bit macro_on = 1'b1;

  neuromorphic_x1_ctrl dut (
    .CLKin(CLKin), .RSTin(RSTin),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .EN(EN), .R_WB(R_WB), .DI(DI), .AD(AD), .SEL(SEL),
    .DO(DO), .func_ack(func_ack)
  );

  always #5 CLKin = ~CLKin;

  // Macro model: a write pulse is queued and acked one cycle later; a held read
  // returns the oldest queued byte after RD_DLY cycles and is popped when EN falls.
  logic [7:0] mq[$];
  bit wr_stage = 0, wr_hi = 0, rd_active = 0, rd_acked = 0;
  int rd_cnt = 0;
  always @(negedge CLKin) begin
    if (!RSTin) begin
      func_ack = 1'b0; wr_stage = 0; wr_hi = 0; rd_active = 0; rd_acked = 0;
      mq.delete();
    end else begin
      if (wr_hi) begin func_ack = 1'b0; wr_hi = 0; end
      if (wr_stage) begin func_ack = 1'b1; wr_hi = 1; wr_stage = 0; end
      if (EN && !R_WB && macro_on) begin mq.push_back(DI[7:0]); wr_stage = 1; end
      if (EN && R_WB) begin
        if (!rd_active) begin rd_active = 1; rd_cnt = RD_DLY; end
        else if (rd_cnt > 0) rd_cnt--;
        if (rd_cnt == 0 && macro_on && !rd_acked) begin
          DO = (mq.size() > 0) ? {24'd0, mq[0]} : 32'd0;
          func_ack = 1'b1;
          rd_acked = 1;
        end
      end else if (rd_active) begin
        rd_active = 0;
        if (rd_acked) begin
          func_ack = 1'b0;
          rd_acked = 0;
          if (mq.size() > 0) void'(mq.pop_front());
        end
      end
    end
  end

  // EN pulse monitor: one record per pulse with its length and preceding low run.
  typedef struct {
    int len; int gap; logic rw; logic [31:0] di; logic [31:0] ad; logic [3:0] sel;
  } pulse_t;
  pulse_t plog[$];
  pulse_t mon_p;
  int     low_run = 1000;
  logic   en_prev = 1'b0;
  always @(negedge CLKin) begin
    if (EN === 1'b1) begin
      if (!en_prev) begin
        mon_p.len = 0; mon_p.gap = low_run; mon_p.rw = R_WB;
        mon_p.di = DI; mon_p.ad = AD; mon_p.sel = SEL;
        plog.push_back(mon_p);
      end
      plog[plog.size()-1].len = plog[plog.size()-1].len + 1;
      low_run = 0;
      en_prev = 1'b1;
    end else begin
      low_run++;
      en_prev = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge CLKin);
    #1;
  endtask

  // One Wishbone classic cycle; lat counts edges after the sampling edge until ack.
  task automatic wb(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel, output logic [31:0] rd, output int lat);
    bit got = 0;
    @(negedge CLKin);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    rd = 32'hx; lat = -1;
    for (int i = 1; i <= MAXW; i++) begin
      @(posedge CLKin); #1;
      if (wbs_ack_o) begin lat = i - 1; rd = wbs_dat_o; got = 1; break; end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) check("wb_ack_wait", 32'(got), 32'd1);
    @(posedge CLKin); #1;
  endtask

  task automatic do_reset();
    RSTin = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    repeat (3) @(posedge CLKin);
    @(negedge CLKin);
    RSTin = 1'b1;
    wait_cycles(2);
  endtask

  typedef struct {
    logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel;
    logic [31:0] exp_dat; int exp_lat; int exp_pulses;
  } vec_t;
  vec_t vecs[$];

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, d, tmp;
    int lat, base, bad_gap, bad_len, ack_seen;
    int ref_pend;
    logic [2:0] ref_flags;
    logic [15:0] ref_timeout;
    logic [7:0] ref_q[$];
    logic [31:0] exp;
    vec_t v;
    pulse_t p;

    do_reset();
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_en", 32'(EN), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_di_ad", DI | AD, 32'd0);
    check("rst_sel_rwb", {27'd0, SEL, R_WB}, 32'd0);

    //          we    adr           dat           sel   exp_dat       lat pulses
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b0, 32'h1000_0008, 32'h0,        4'hF, 32'h0000_07FF, 1, 0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b1, 32'h0000_000C, 32'hDEADBEEF, 4'hF, 32'h0,         1, 0});
    vecs.push_back('{1'b0, 32'h0000_000C, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'hABCD1234, 4'hF, 32'h0,         1, 0});
    vecs.push_back('{1'b0, 32'h0000_0008, 32'h0,        4'hF, 32'h0000_1234, 1, 0});
    vecs.push_back('{1'b1, 32'h0000_0008, 32'h0000_07FF, 4'hF, 32'h0,        1, 0});
    vecs.push_back('{1'b1, 32'h0000_0000, 32'h0660_00A5, 4'hF, 32'h0,        3, 1});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0001, 1, 0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0000_00A5, -1, 1});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0002_0000, 1, 0});
    vecs.push_back('{1'b1, 32'h0000_0004, 32'h0002_0000, 4'hF, 32'h0,        1, 0});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0000, 1, 0});
    vecs.push_back('{1'b1, 32'hF000_0010, 32'h1234_5678, 4'h3, 32'h0,        3, 1});
    vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,        4'hF, 32'h0000_0078, -1, 1});
    vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,        4'hF, 32'h0000_0000, 1, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      wait_cycles(4);
      base = plog.size();
      wb(v.we, v.adr, v.dat, v.sel, rd, lat);
      if (!v.we) check($sformatf("vec%0d_data", i), rd, v.exp_dat);
      if (v.exp_lat >= 0) check($sformatf("vec%0d_latency", i), 32'(lat), 32'(v.exp_lat));
      check($sformatf("vec%0d_en_pulses", i), 32'(plog.size() - base), 32'(v.exp_pulses));
      if (v.exp_pulses == 1 && plog.size() > base) begin
        p = plog[base];
        check($sformatf("vec%0d_rwb", i), 32'(p.rw), 32'(!v.we));
        check($sformatf("vec%0d_ad", i), p.ad, v.adr);
        check($sformatf("vec%0d_sel", i), 32'(p.sel), 32'(v.sel));
        if (v.we) begin
          check($sformatf("vec%0d_di", i), p.di, v.dat);
          check($sformatf("vec%0d_wr_len", i), 32'(p.len), 32'd1);
        end else begin
          check($sformatf("vec%0d_rd_held", i), 32'(p.len >= RD_DLY), 32'd1);
        end
      end
    end

    // 33 back-to-back writes: 32 pulses with gaps, then an overflow rejection.
    wait_cycles(4);
    base = plog.size();
    for (int i = 0; i < 32; i++) wb(1'b1, 32'h0, $urandom(), 4'hF, rd, lat);
    wait_cycles(4);
    wb(1'b1, 32'h0, 32'h0000_0099, 4'hF, rd, lat);
    check("burst_ovf_latency", 32'(lat), 32'd1);
    check("burst_pulses", 32'(plog.size() - base), 32'd32);
    bad_gap = 0; bad_len = 0;
    for (int k = base; k < plog.size(); k++) begin
      if (k > base && plog[k].gap < 2) bad_gap++;
      if (plog[k].len != 1) bad_len++;
    end
    check("burst_gap_violations", 32'(bad_gap), 32'd0);
    check("burst_len_violations", 32'(bad_len), 32'd0);
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("burst_status", rd, 32'h0001_0020);

    // Random traffic against a queue-based reference model.
    do_reset();
    ref_pend = 0; ref_flags = 3'b000; ref_timeout = 16'h07FF; ref_q.delete();
    for (int i = 0; i < 80; i++) begin
      int op = $urandom_range(0, 9);
      d = $urandom();
      case (op)
        0, 1, 2, 3: begin
          wb(1'b1, 32'h0, d, 4'hF, rd, lat);
          if (ref_pend == 32) ref_flags[0] = 1'b1;
          else begin ref_q.push_back(d[7:0]); ref_pend++; end
        end
        4, 5: begin
          wb(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
          if (ref_pend == 0) begin exp = 32'd0; ref_flags[1] = 1'b1; end
          else begin exp = {24'd0, ref_q.pop_front()}; ref_pend--; end
          check($sformatf("rand%0d_data_read", i), rd, exp);
        end
        6: begin
          wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
          check($sformatf("rand%0d_status", i), rd,
                {13'd0, ref_flags, 10'd0, 6'(ref_pend)});
        end
        7: begin
          wb(1'b1, 32'h4, d, 4'hF, rd, lat);
          ref_flags = ref_flags & ~d[18:16];
        end
        8: begin
          if (d[0]) begin
            tmp = {d[31:16], 16'($urandom_range(100, 400))};
            wb(1'b1, 32'h8, tmp, 4'hF, rd, lat);
            ref_timeout = tmp[15:0];
          end else begin
            wb(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
            check($sformatf("rand%0d_timeout", i), rd, {16'd0, ref_timeout});
          end
        end
        default: begin
          wb(d[0], 32'hC, d, 4'hF, rd, lat);
          if (!d[0]) check($sformatf("rand%0d_reserved", i), rd, 32'd0);
        end
      endcase
    end
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("rand_final_status", rd, {13'd0, ref_flags, 10'd0, 6'(ref_pend)});

    // Reset while a read is held: EN must drop at once with no ack.
    do_reset();
    wb(1'b1, 32'h0, 32'h0000_0011, 4'hF, rd, lat);
    wait_cycles(4);
    @(negedge CLKin);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0;
    wait_cycles(5);
    check("rstmid_en_before", 32'(EN), 32'd1);
    RSTin = 1'b0;
    #1;
    check("rstmid_en_after", 32'(EN), 32'd0);
    check("rstmid_ack", 32'(wbs_ack_o), 32'd0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge CLKin);
    RSTin = 1'b1;
    wait_cycles(2);
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("rstmid_status", rd, 32'h0);

    // Dropping cyc mid-write: no ack, but the pending count still advances.
    wait_cycles(4);
    @(negedge CLKin);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h0; wbs_dat_i = 32'h0000_0033;
    wait_cycles(1);
    check("cycdrop_en", 32'(EN), 32'd1);
    wait_cycles(1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLKin); #1;
      if (wbs_ack_o) ack_seen++;
    end
    check("cycdrop_no_ack", 32'(ack_seen), 32'd0);
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("cycdrop_status", rd, 32'h0000_0001);

    // Timeouts with the macro silent.
    macro_on = 1'b0;
    wb(1'b1, 32'h8, 32'h0000_0008, 4'hF, rd, lat);
    wait_cycles(4);
    base = plog.size();
    wb(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
    check("tmo8_data", rd, 32'hFFFF_FFFF);
    check("tmo8_pulses", 32'(plog.size() - base), 32'd1);
    if (plog.size() > base) check("tmo8_en_len", 32'(plog[base].len), 32'd8);
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("tmo8_status", rd, 32'h0004_0001);

    wb(1'b1, 32'h8, 32'h0000_0000, 4'hF, rd, lat);
    wb(1'b1, 32'h4, 32'h0004_0000, 4'hF, rd, lat);
    wait_cycles(4);
    base = plog.size();
    wb(1'b0, 32'h0, 32'h0, 4'hF, rd, lat);
    check("tmo0_data", rd, 32'hFFFF_FFFF);
    if (plog.size() > base) check("tmo0_en_len", 32'(plog[base].len), 32'd1);
    else check("tmo0_pulses", 32'(plog.size() - base), 32'd1);
    wb(1'b1, 32'h4, 32'h0004_0000, 4'hF, rd, lat);
    wait_cycles(4);
    wb(1'b1, 32'h0, 32'h0000_0044, 4'hF, rd, lat);
    check("tmo_wr_latency", 32'(lat), 32'd3);
    wb(1'b0, 32'h4, 32'h0, 4'hF, rd, lat);
    check("tmo_wr_status", rd, 32'h0004_0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/neuromorphic_x1_ctrl.md
# neuromorphic_x1_ctrl

Wishbone-slave-to-macro initiator for the 32x32 ReRAM neuromorphic array. Accepts CPU Wishbone classic cycles, converts DATA-register accesses into correctly shaped macro write pulses and held read requests, and waits for `func_ack` with a programmable timeout. It tracks the macro's 32-entry pending-write depth so it never overflows or underflows the macro. Sits between the user-project Wishbone bus and the macro's EN/R_WB/DI/AD/SEL/DO/func_ack pins.

## Interface
- `TIMEOUT_RST`, default 16'd2047: reset value of the TIMEOUT register, in cycles.
- `MAX_PEND`, default 32: macro queue depth.
- `ISSUE_GAP`, default 2: minimum number of EN-low cycles between consecutive macro operations.

Ports (reset RSTin, asynchronous, active-low; clock CLKin):
- `CLKin` input 1: clock.
- `RSTin` input 1: asynchronous active-low reset.
- `wbs_cyc_i` input 1: Wishbone cycle.
- `wbs_stb_i` input 1: Wishbone strobe.
- `wbs_we_i` input 1: Wishbone write enable.
- `wbs_sel_i` input 4: byte select.
- `wbs_adr_i` input 32: address; only [3:2] is decoded.
- `wbs_dat_i` input 32: write data.
- `wbs_ack_o` output 1: one-cycle acknowledge.
- `wbs_dat_o` output 32: read data.
- `EN` output 1: macro enable.
- `R_WB` output 1: 1 = read, 0 = write.
- `DI` output 32: macro write word; row [29:25], column [24:20], data [7:0].
- `AD` output 32: captured `wbs_adr_i`.
- `SEL` output 4: captured `wbs_sel_i`.
- `DO` input 32: macro read data.
- `func_ack` input 1: macro acknowledge.

## Operation
- Address map, selected by `adr[3:2]`:
  - 0 = DATA (macro access).
  - 1 = STATUS: bits [5:0] pend_cnt, [8] busy, [16] overflow, [17] underflow, [18] timeout. All other bits read 0. Bits 18:16 are write-1-to-clear.
  - 2 = TIMEOUT: [15:0] read/write, upper bits read 0.
  - 3 = reserved: reads 0, writes are ignored.
- FSM states: IDLE, GAP, WR_ISSUE, WR_WAIT, RD_WAIT, ACK.
- IDLE: a request (cyc & stb) is accepted only when the gap counter is 0.
  - STATUS, TIMEOUT or reserved access → ACK.
  - DATA write with pend_cnt == MAX_PEND → no EN, set overflow → ACK.
  - DATA read with pend_cnt == 0 → no EN, set underflow, wbs_dat_o = 0 → ACK.
  - DATA write otherwise → drive DI = wbs_dat_i, AD, SEL, R_WB = 0, EN = 1 → WR_ISSUE.
  - DATA read otherwise → R_WB = 1, EN = 1, AD, SEL → RD_WAIT.
- WR_ISSUE: lasts exactly one cycle. EN is 0 from the next edge, so every write pulse is a single cycle. Load the timeout counter, then → WR_WAIT.
- WR_WAIT: on func_ack = 1, pend_cnt++ → ACK. On timeout counter reaching 0, set timeout, pend_cnt unchanged → ACK.
- RD_WAIT: EN is held high continuously until exit, because the macro aborts a read if EN drops.
  - On func_ack = 1: capture DO into wbs_dat_o, pend_cnt--, EN = 0 → ACK.
  - On timeout: EN = 0, wbs_dat_o = 32'hFFFF_FFFF, set timeout, pend_cnt unchanged → ACK.
- ACK: wbs_ack_o = 1 for exactly one cycle, only if wbs_cyc_i is still high; otherwise the ack is suppressed. Load the gap counter with ISSUE_GAP if a macro op occurred, else 0 → IDLE.
- GAP handling: the gap counter decrements in IDLE, and requests stall while it is nonzero.
- Timeout counter: 16-bit, loaded from TIMEOUT, decrements once per wait cycle. TIMEOUT = 0 is treated as 1.
- Dropping wbs_cyc_i mid-operation does not abort the macro op; counters and flags still update.
- If a flag W1C clear and a flag set occur on the same edge, the set wins.
- busy = (state != IDLE) or gap counter ≠ 0.
- pend_cnt saturates at 0 and MAX_PEND.

## Timing
- Reset values: wbs_ack_o = 0, wbs_dat_o = 0, EN = 0, R_WB = 0, DI = 0, AD = 0, SEL = 0, pend_cnt = 0, all flags = 0, TIMEOUT = TIMEOUT_RST, state = IDLE.
- Asserting RSTin mid-operation forces EN low immediately and abandons the transaction with no ack.
- All outputs are registered.
- Register access: request sampled at edge E0; wbs_ack_o is high between E1 and E2.
- Write:
  - EN high between E0 and E1.
  - The macro responds with func_ack after E1.
  - The controller samples func_ack at E2; wbs_ack_o is high between E3 and E4.
  - Nominal total: 3 cycles from request to ack.
- Read: EN rises after E0 and stays high through the edge at which func_ack is sampled. wbs_ack_o follows one cycle later, with the DO value captured at that edge.
- Overflow/underflow rejection: ack one cycle after the request is sampled, no EN activity.

## Test plan
- Reset, then read STATUS and TIMEOUT → 0x0000_0000 and 0x0000_07FF; EN stays 0.
- Write DATA 0x0660_00A5 → exactly one EN = 1 cycle with R_WB = 0 and DI = 0x0660_00A5; ack 3 cycles after request; STATUS = 0x0000_0001.
- Then read DATA against the macro model (RD_Dly = 44) → EN high continuously with no gap until func_ack; wbs_dat_o = 0x0000_00A5; STATUS pend_cnt = 0.
- Read DATA with pend_cnt = 0 → no EN; ack next cycle with data 0; STATUS bit 17 set. Write 0x0002_0000 to STATUS → bit 17 cleared.
- 33 back-to-back DATA writes:
  - The first 32 each produce one EN pulse, with ≥ 2 EN-low cycles between pulses.
  - The 33rd is acked with no EN; STATUS = 0x0001_0020.
- TIMEOUT = 8, func_ack stubbed to 0, pend_cnt = 1, read DATA → EN high 8 cycles then low; ack with data 0xFFFF_FFFF; STATUS bit 18 set, pend_cnt still 1.
